// File: rtl/axis_fir_coeff_loader.sv
// axis_fir_coeff_loader
//   Writer side of the sequential FIR coefficient port. Accepts one AXI-Stream
//   packet of coefficient words, writes them to addresses 0..N_HALF-1 of the
//   symmetric filter's coefficient register, checks the packet length and
//   drives FILTER_HOLD so the system can stall filter input during an update.
//
//   Optional build macro: AXIS_FIR_COEFF_LOADER_SHADOW_EN
//     undefined - write-through: each accepted beat is written one cycle later.
//     defined   - beats are captured in a shadow buffer and only committed to
//                 the filter (as a burst of back-to-back writes) when the packet
//                 length is correct.
//
// Ports
//   CLK            in   single clock, all logic on posedge
//   RESET          in   synchronous, active-high
//   S_AXIS_TDATA   in   coefficient word (N_BYTES*8 bits)
//   S_AXIS_TVALID  in   coefficient word valid
//   S_AXIS_TLAST   in   last word of packet
//   S_AXIS_TREADY  out  loader ready
//   COEFF_ADDR     out  write address (zero-extended word index)
//   COEFF_DATA     out  write data, bit-exact copy of TDATA
//   COEFF_VALID    out  one-cycle write strobe per word
//   FILTER_HOLD    out  high while a coefficient update is in progress
//   LOAD_DONE      out  one-cycle pulse: correct packet fully written
//   LOAD_ERROR     out  one-cycle pulse: packet length was wrong

module axis_fir_coeff_loader #(
    parameter int unsigned N_BYTES          = 4,
    parameter int unsigned COEFF_ADDR_WIDTH = 6
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [N_BYTES*8-1:0]        S_AXIS_TDATA,
    input  logic                        S_AXIS_TVALID,
    input  logic                        S_AXIS_TLAST,
    output logic                        S_AXIS_TREADY,
    output logic [COEFF_ADDR_WIDTH-1:0] COEFF_ADDR,
    output logic [N_BYTES*8-1:0]        COEFF_DATA,
    output logic                        COEFF_VALID,
    output logic                        FILTER_HOLD,
    output logic                        LOAD_DONE,
    output logic                        LOAD_ERROR
);

    localparam int unsigned DataW = N_BYTES * 8;
    localparam int unsigned IdxW  = COEFF_ADDR_WIDTH - 1;
    localparam int unsigned NHalf = 2 ** IdxW;
    localparam logic [IdxW-1:0] LastIdx = '1;

`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StResp, StCommit} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StResp} state_e;
`endif

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic              accept;

    assign accept = S_AXIS_TVALID & S_AXIS_TREADY;

`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
    // Shadow buffer: no reset needed, a word is only read after being written
    // by a packet of correct length.
    logic [DataW-1:0] shadow_buf [NHalf];

    always_ff @(posedge CLK) begin
        if (accept && (state_q == StIdle || state_q == StLoad)) begin
            shadow_buf[idx_q] <= S_AXIS_TDATA;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            S_AXIS_TREADY <= 1'b0;
            COEFF_ADDR    <= '0;
            COEFF_DATA    <= '0;
            COEFF_VALID   <= 1'b0;
            FILTER_HOLD   <= 1'b0;
            LOAD_DONE     <= 1'b0;
            LOAD_ERROR    <= 1'b0;
        end else begin
            // Pulses default low; TREADY defaults high and is pulled low only
            // on entry to (or while staying in) a non-accepting state.
            COEFF_VALID   <= 1'b0;
            LOAD_DONE     <= 1'b0;
            LOAD_ERROR    <= 1'b0;
            S_AXIS_TREADY <= 1'b1;

            unique case (state_q)
                // IDLE always has idx_q == 0, so it shares the LOAD decoding.
                StIdle, StLoad: begin
                    if (accept) begin
`ifndef AXIS_FIR_COEFF_LOADER_SHADOW_EN
                        COEFF_VALID <= 1'b1;
                        COEFF_ADDR  <= {1'b0, idx_q};
                        COEFF_DATA  <= S_AXIS_TDATA;
                        FILTER_HOLD <= 1'b1;
`endif
                        if (S_AXIS_TLAST) begin
                            S_AXIS_TREADY <= 1'b0;
                            if (idx_q == LastIdx) begin
`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
                                // Word 0 is already in the buffer, so the
                                // first commit write issues right away.
                                state_q     <= StCommit;
                                COEFF_VALID <= 1'b1;
                                COEFF_ADDR  <= '0;
                                COEFF_DATA  <= shadow_buf[0];
                                FILTER_HOLD <= 1'b1;
                                idx_q       <= IdxW'(1);
`else
                                state_q   <= StResp;
                                LOAD_DONE <= 1'b1;
                                idx_q     <= '0;
`endif
                            end else begin
                                state_q    <= StResp;
                                LOAD_ERROR <= 1'b1;
                                idx_q      <= '0;
                            end
                        end else if (idx_q == LastIdx) begin
                            state_q <= StDrain;
                            idx_q   <= '0;
                        end else begin
                            state_q <= StLoad;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (accept && S_AXIS_TLAST) begin
                        state_q       <= StResp;
                        LOAD_ERROR    <= 1'b1;
                        S_AXIS_TREADY <= 1'b0;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    FILTER_HOLD <= 1'b0;
                end
`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
                StCommit: begin
                    // LOAD_DONE high means the final write is on the port now.
                    if (LOAD_DONE) begin
                        state_q     <= StIdle;
                        FILTER_HOLD <= 1'b0;
                        idx_q       <= '0;
                    end else begin
                        S_AXIS_TREADY <= 1'b0;
                        COEFF_VALID   <= 1'b1;
                        COEFF_ADDR    <= {1'b0, idx_q};
                        COEFF_DATA    <= shadow_buf[idx_q];
                        idx_q         <= idx_q + 1'b1;
                        if (idx_q == LastIdx) begin
                            LOAD_DONE <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
